// File: rtl/simon_keyexpansion_rev.sv
// SIMON reverse key schedule: loaded with the last four round keys, it regenerates
// and emits every round key from k[T-1] down to k[0], one per accepted handshake.
module simon_keyexpansion_rev #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int Cb = 5
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [M-1:0][N-1:0]   lKeys,
    output logic [N-1:0]          key_out,
    output logic [Cb-1:0]         key_idx,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  last
);

    // state | meaning
    // IDLE  | waiting for a load of k[T-4..T-1]; load_ready high
    // RUN   | w[3] = k[idx] presented on key_out; steps down on each accept

    generate
        if (M != 4) begin : g_bad_m
            $error("simon_keyexpansion_rev: only M=4 is supported");
        end
        if ((2 ** Cb) < T) begin : g_bad_cb
            $error("simon_keyexpansion_rev: Cb too narrow for T");
        end
    endgenerate

    localparam logic [61:0] ZSEQ   = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [N-1:0] CONST3 = N'(3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [M-1:0][N-1:0] w;
    logic [Cb-1:0]       idx;

    logic [31:0]  zpos;
    logic         zbit;
    logic [N-1:0] t0;
    logic [N-1:0] t;
    logic [N-1:0] nxt;

    // Inverse of the forward step k[i+4] = ~3 ^ z[i] ^ k[i] ^ f(k[i+3], k[i+1]), with i = idx-4
    always_comb begin
        zpos = (32'(idx) - 32'd4) % 32'd62;
        zbit = 1'b0;
        for (int j = 0; j < 62; j++) begin
            if (zpos == 32'(j)) zbit = ZSEQ[j];
        end
        t0  = {w[2][2:0], w[2][N-1:3]} ^ w[0];
        t   = t0 ^ {t0[0], t0[N-1:1]};
        nxt = '0;
        if (idx >= Cb'(4)) nxt = ~(w[3] ^ t ^ {{(N-1){1'b0}}, zbit} ^ CONST3);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            w          <= '0;
            idx        <= '0;
            load_ready <= 1'b1;
            key_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        w          <= lKeys;
                        idx        <= Cb'(T - 1);
                        state      <= RUN;
                        load_ready <= 1'b0;
                        key_valid  <= 1'b1;
                    end
                end
                RUN: begin
                    if (key_ready) begin
                        if (idx == '0) begin
                            state      <= IDLE;
                            key_valid  <= 1'b0;
                            load_ready <= 1'b1;
                        end else begin
                            idx  <= idx - Cb'(1);
                            w[3] <= w[2];
                            w[2] <= w[1];
                            w[1] <= w[0];
                            w[0] <= nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_out = w[3];
    assign key_idx = idx;
    assign last    = key_valid & (idx == '0);

endmodule

// File: doc/simon_keyexpansion_rev.md
Name: simon_keyexpansion_rev

Overview:
- Sequential reverse key schedule for SIMON decryption.
- Loaded with the last M round keys k[T-M..T-1], it emits all T round keys in descending order, k[T-1] down to k[0], one per accepted handshake.
- Each earlier key is regenerated by inverting the forward expansion step.
- Sits between the key store and the decryption round datapath, so the decryptor never needs a T-entry key RAM.

Parameters:
N, 16, word width in bits
M, 4, key words; only M=4 supported (elaboration-time assertion)
T, 32, number of round keys
Cb, 5, width of the round index; must satisfy 2^Cb >= T

Ports:
clk  input  1  system clock, rising edge
nReset  input  1  reset
load_valid  input  1  lKeys valid
load_ready  output  1  block can accept a load
lKeys  input  M*N (packed [M-1:0][N-1:0])  lKeys[0]=k[T-4], lKeys[1]=k[T-3], lKeys[2]=k[T-2], lKeys[3]=k[T-1]
key_out  output  N  current round key k[key_idx]
key_idx  output  Cb  index of key_out
key_valid  output  1  key_out valid
key_ready  input  1  consumer accepts key_out
last  output  1  key_valid and key_idx==0

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- State: FSM {IDLE, RUN}, window registers w[3:0], index register idx.
- Invariant in RUN: w[3]=k[idx], w[2]=k[idx-1], w[1]=k[idx-2], w[0]=k[idx-3].
- key_out=w[3], key_idx=idx; both are registered outputs.
- Reset (asserted asynchronously at any time, including mid-RUN):
  - state=IDLE; w=0; idx=0.
  - load_ready=1 and key_valid=0 once reset is released.
  - All outputs are 0 except load_ready.
- IDLE:
  - load_ready=1, key_valid=0.
  - On load_valid: w<=lKeys, idx<=T-1, go to RUN.
  - key_valid rises the cycle after the load; latency 1 cycle.
- RUN:
  - load_ready=0; load_valid is ignored. There is no preemption or reload until the sequence completes.
  - key_valid=1.
  - key_ready low: hold w, idx and key_out stable.
- Accept (key_valid & key_ready) in RUN:
  - If idx==0: return to IDLE, key_valid=0 next cycle, load_ready=1 next cycle. Back-to-back load is possible one cycle later.
  - Else: idx<=idx-1 and the window shifts down: w[3]<=w[2], w[2]<=w[1], w[1]<=w[0], w[0]<=nxt.
- Next-key computation, idx>=4: nxt=k[idx-4] = ~(w[3] ^ t ^ zc ^ 16'h0003).
  - t0 = ROR(w[2],3) ^ w[0]
  - t = t0 ^ ROR(t0,1)
  - zc = z bit (idx-4) mod 62, zero-extended into the LSB.
  - z is the 62-bit constant 62'b01100111000011010100100010111110110011100001101010010001011111; bit 0 is the LSB (standard z0 sequence, z[0]=1).
- Next-key computation, idx<4: nxt=0. This is a don't-care slot that is never emitted.
- Throughput: one key per cycle with key_ready held high; T keys in T cycles after the load.
- All arithmetic is N-bit; rotates are within N bits.
- The modulo is computed on the Cb-bit index. The required case is T<=62, where (idx-4) mod 62 = idx-4.

Test Plan:
1. Smoke, T=6: load lKeys={0xB649,0x71C3,0x1918,0x1110} (lKeys[3]..[0]), key_ready=1 -> key_out sequence 0xB649,0x71C3,0x1918,0x1110,0x0908,0x0100 with key_idx 5..0; last only on 0x0100; load_ready returns the next cycle.
2. Default T=32: expand the key 1918 1110 0908 0100 with the golden forward model, load k28..k31 -> 32 outputs equal the model in reverse order, including the idx-4 z bit indexing.
3. Backpressure: randomly toggle key_ready during scenario 1 -> key_out and key_idx stay stable while stalled; no key is lost or duplicated; the sequence is unchanged.
4. Load during RUN: pulse load_valid with different lKeys mid-sequence -> load_ready=0; the sequence continues unaffected.
5. Reset mid-RUN: assert nReset at idx=3 -> outputs clear immediately, asynchronously (key_valid=0, key_out=0); after release load_ready=1 and a fresh load restarts at idx=T-1.
6. Back-to-back loads: load_valid held high -> the second load is accepted the cycle after the last accept; the gap is exactly 1 cycle with key_valid=0.
